// File: rtl/mem_stage_if.sv
// Execute -> memory-stage bundle: execute beat, data-memory req/ack port and write-back beat.
// The slave modport is the stage itself; master is the surrounding pipeline/memory.
interface mem_stage_if #(
  parameter int ADDR_W = 10,
  parameter int RD_W   = 5
);
  logic              ex_vld;
  logic              ex_rdy;
  logic [31:0]       ex_x_rd;
  logic              ex_x_rd_vld;
  logic [RD_W-1:0]   ex_rd_idx;
  logic [ADDR_W-1:0] ex_mem_addr;
  logic [3:0]        ex_mem_rden;
  logic [3:0]        ex_mem_wren;
  logic [31:0]       ex_mem_wrdata;

  logic              dmem_req;
  logic              dmem_we;
  logic [3:0]        dmem_be;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;

  logic              wb_vld;
  logic [RD_W-1:0]   wb_rd_idx;
  logic [31:0]       wb_data;

  modport slave (
    input  ex_vld, ex_x_rd, ex_x_rd_vld, ex_rd_idx,
    input  ex_mem_addr, ex_mem_rden, ex_mem_wren, ex_mem_wrdata,
    output ex_rdy,
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata,
    output wb_vld, wb_rd_idx, wb_data
  );

  modport master (
    output ex_vld, ex_x_rd, ex_x_rd_vld, ex_rd_idx,
    output ex_mem_addr, ex_mem_rden, ex_mem_wren, ex_mem_wrdata,
    input  ex_rdy,
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata,
    input  wb_vld, wb_rd_idx, wb_data
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access / write-back-select stage: ALU results pass through, loads/stores use a req/ack port.
// Define MEM_TIMEOUT_EN to abort a WAIT that sees no ack within MAX_WAIT cycles (sets error).
module mem_stage #(
  parameter int ADDR_W = 10,
  parameter int RD_W   = 5
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int MAX_WAIT = 15
`endif
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus,
  output logic        error
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic            has_rd;
  logic            has_wr;
  logic            is_alu;
  logic            is_mem;
  logic            is_bad;
  logic            mem_done;
  logic            timeout;
  logic [RD_W-1:0] req_rd_idx;
  logic [31:0]     load_data;

  assign bus.ex_rdy = (state == IDLE);
  assign accept     = bus.ex_vld && bus.ex_rdy;
  assign has_rd     = |bus.ex_mem_rden;
  assign has_wr     = |bus.ex_mem_wren;
  assign is_alu     = accept && !has_rd && !has_wr;
  assign is_mem     = accept && (has_rd ^ has_wr);
  assign is_bad     = accept && has_rd && has_wr;
  assign mem_done   = (state == WAIT) && bus.dmem_ack;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Fires on the cycle the count would reach MAX_WAIT, i.e. after MAX_WAIT ack-less WAIT cycles.
  assign timeout = (state == WAIT) && !bus.dmem_ack && (wait_cnt == CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (is_mem) begin
      wait_cnt <= '0;
    end else if ((state == WAIT) && !bus.dmem_ack) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (is_mem) state_nxt = WAIT;
      WAIT:    if (mem_done || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lanes not enabled for the load read back as zero.
  always_comb begin
    load_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (bus.dmem_be[i]) load_data[8*i +: 8] = bus.dmem_rdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_be    <= '0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      bus.wb_vld     <= 1'b0;
      bus.wb_rd_idx  <= '0;
      bus.wb_data    <= '0;
      req_rd_idx     <= '0;
      error          <= 1'b0;
    end else begin
      bus.wb_vld <= 1'b0;

      if (is_alu) begin
        bus.wb_vld    <= bus.ex_x_rd_vld && (bus.ex_rd_idx != '0);
        bus.wb_rd_idx <= bus.ex_rd_idx;
        bus.wb_data   <= bus.ex_x_rd;
      end

      // Request fields are captured once and held untouched for the whole WAIT.
      if (is_mem) begin
        bus.dmem_req   <= 1'b1;
        bus.dmem_we    <= has_wr;
        bus.dmem_be    <= has_wr ? bus.ex_mem_wren : bus.ex_mem_rden;
        bus.dmem_addr  <= bus.ex_mem_addr;
        bus.dmem_wdata <= bus.ex_mem_wrdata;
        req_rd_idx     <= bus.ex_rd_idx;
      end

      if (is_bad) error <= 1'b1;

      if (mem_done) begin
        bus.dmem_req <= 1'b0;
        if (!bus.dmem_we) begin
          bus.wb_vld    <= (req_rd_idx != '0);
          bus.wb_rd_idx <= req_rd_idx;
          bus.wb_data   <= load_data;
        end
      end

      if (timeout) begin
        bus.dmem_req <= 1'b0;
        error        <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access / write-back-select stage directly downstream of the execute stage.
- Accepts one execute result per handshake: an ALU value, a load request or a store request.
- Load/store ops drive a variable-latency data-memory req/ack port; ALU results pass through.
- Presents one registered write-back beat (rd index + data) to the register file.

Parameters:
- ADDR_W, 10, data-memory word-address width (matches execute MEMaddr width).
- RD_W, 5, destination register index width.
- MAX_WAIT, 15, ack timeout in cycles; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ex_vld  in  1  execute beat valid.
- ex_rdy  out  1  stage can accept a beat; combinational, high only in IDLE.
- ex_x_rd  in  32  ALU result.
- ex_x_rd_vld  in  1  instruction writes rd.
- ex_rd_idx  in  RD_W  destination register.
- ex_mem_addr  in  ADDR_W  word address.
- ex_mem_rden  in  4  byte read enables.
- ex_mem_wren  in  4  byte write enables.
- ex_mem_wrdata  in  32  store data.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_be  out  4  byte enables.
- dmem_addr  out  ADDR_W  address.
- dmem_wdata  out  32  write data.
- dmem_ack  in  1  one-cycle completion pulse.
- dmem_rdata  in  32  read data, valid with dmem_ack.
- wb_vld  out  1  write-back strobe, one cycle.
- wb_rd_idx  out  RD_W  write-back register.
- wb_data  out  32  write-back data.
- error  out  1  sticky fault flag.

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high.
- Reset values: state = IDLE; dmem_req = 0; dmem_we = 0; dmem_be = 0; dmem_addr = 0; dmem_wdata = 0; wb_vld = 0; wb_rd_idx = 0; wb_data = 0; error = 0; wait counter = 0.
- Reset asserted mid-WAIT abandons the access: dmem_req drops the next cycle and no write-back occurs.
- FSM states: IDLE and WAIT.
- A beat is accepted when ex_vld and ex_rdy are both high.
- IDLE, accepted beat with rden = 0 and wren = 0 (ALU op):
  - next cycle wb_vld = ex_x_rd_vld AND (ex_rd_idx != 0), wb_data = ex_x_rd, wb_rd_idx = ex_rd_idx.
  - latency 1; back-to-back beats every cycle allowed.
- IDLE, accepted beat with exactly one of rden / wren nonzero:
  - capture request; next cycle dmem_req = 1, dmem_we = (wren != 0), dmem_be = the nonzero enable vector, dmem_addr, dmem_wdata; go to WAIT.
  - wb_vld = 0 for that cycle.
- IDLE, accepted beat with rden and wren both nonzero: error = 1, no memory access, no write-back, stay in IDLE.
- WAIT:
  - ex_rdy = 0; all dmem_* outputs held stable.
  - Earliest legal ack is the first cycle dmem_req is high.
  - On dmem_ack: dmem_req = 0 next cycle; return to IDLE.
  - Load completion: next cycle wb_vld = (rd_idx != 0); wb_data = dmem_rdata with each byte lane whose be bit is 0 forced to 0x00. Latency from acceptance to wb_vld is ack wait + 2.
  - Store completion: no write-back beat.
- dmem_ack while in IDLE is ignored and sets no error.
- wb_vld is never high two cycles in a row for the same beat.
- Write-back to rd index 0 is always suppressed.
- error is sticky until rst.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined: counter increments each WAIT cycle without ack. When it reaches MAX_WAIT, the stage sets error = 1, drops dmem_req, returns to IDLE and issues no write-back. The counter clears on entry to WAIT.
- Undefined: no counter; WAIT holds indefinitely until dmem_ack.

Test Plan:
- Reset then ALU beat x_rd = 0x0000_1234, rd = 5, x_rd_vld = 1 -> one cycle later wb_vld = 1, rd 5, data 0x0000_1234; ex_rdy stays 1.
- ALU beat with rd = 0, x_rd = 0xFFFF_FFFF -> wb_vld stays 0.
- Load addr 0x010, rden = 4'b1111, ack 3 cycles after dmem_req with rdata 0xDEAD_BEEF -> ex_rdy low 4 cycles; wb_vld with 0xDEAD_BEEF to rd 7; dmem_* stable throughout WAIT.
- Load rden = 4'b0011, rdata 0xAABB_CCDD -> wb_data 0x0000_CCDD.
- Store wren = 4'b1111, data 0x1357_9BDF, ack same cycle as req -> dmem_we = 1, be 4'hF, no wb_vld; next beat accepted 2 cycles after the store.
- Both enables nonzero -> error = 1, no dmem_req. With MEM_TIMEOUT_EN and MAX_WAIT = 15, a load with no ack -> error after 15 WAIT cycles, dmem_req drops; with rst mid-WAIT -> all outputs return to 0.
